// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and constants for the RAM BIST initiator.
//   state_t      - run sequencer states
//   RAM_WR_*     - RAM op encoding used by the RAM port (0 = write, 1 = read)
//   *_DEF        - default geometry, read latency and test pattern
//   pat_data()   - pattern value for an address: seed + a*step (caller truncates)
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic RAM_WR_WRITE = 1'b0;
    localparam logic RAM_WR_READ  = 1'b1;

    localparam int         AW_DEF       = 3;
    localparam int         DW_DEF       = 8;
    localparam int         RD_LAT_DEF   = 1;
    localparam logic [7:0] PAT_SEED_DEF = 8'h0A;
    localparam logic [7:0] PAT_STEP_DEF = 8'h0A;

    // Full-width result; the caller keeps the low DW bits so overflow is discarded.
    function automatic logic [31:0] pat_data(input logic [31:0] a,
                                             input logic [31:0] seed,
                                             input logic [31:0] step);
        return seed + a * step;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: RAM port bundle between the BIST initiator and the RAM.
//   ram_wr     RAM op: 0 = write, 1 = read
//   ram_addr   RAM address (AW bits)
//   ram_wdata  RAM write data (DW bits)
//   ram_rdata  RAM read data (DW bits), returned by the RAM
// Modports: master (initiator side), slave (RAM side).
interface ram_bist_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (output ram_wr, ram_addr, ram_wdata, input ram_rdata);
    modport slave  (input ram_wr, ram_addr, ram_wdata, output ram_rdata);
endinterface

// File: rtl/ram_bist_rd_pipe.sv
// ram_bist_rd_pipe: RD_LAT-stage delay line of {valid, addr} that tracks each
// issued read until its data comes back from the RAM.
//   clk, rst    clock, synchronous active-high reset
//   flush       drops everything in flight (used when a run aborts)
//   in_valid    a read is issued this cycle
//   in_addr     address of that read
//   out_valid   ram_rdata this cycle belongs to an issued read
//   out_addr    address of that read
module ram_bist_rd_pipe #(
    parameter int AW     = 3,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic [RD_LAT-1:0] valid_q;
    logic [AW-1:0]     addr_q [RD_LAT];

    // NOTE: sequential state is always assigned with <= so every stage samples
    // the value its neighbour held before this edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // NOTE: the address stages carry no reset; they are only looked at when the
    // matching valid bit is set, and valid bits are reset.
    always_ff @(posedge clk) begin
        addr_q[0] <= in_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_q[i] <= addr_q[i-1];
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_bist_master.sv
// ram_bist_master: hardware initiator for the RAM port. On start it writes a
// deterministic pattern (PAT_SEED + a*PAT_STEP) to every address, reads all
// addresses back, compares them and reports pass/fail.
//   clk        clock
//   rst        synchronous active-high reset (wins over everything, mid-run too)
//   start      1-cycle run request, sampled only in IDLE
//   busy       high from the cycle after start until DONE
//   done       1-cycle pulse when a run finishes
//   pass       result of the last run, valid from done until the next start
//   fail_addr  address of the first mismatch, 0 if none
//   err_count  mismatch count of the last run, saturating at 2**AW
//              (present only with RAM_BIST_ERRCNT_EN)
//   ram        RAM port (ram_bist_if.master)
// Build option RAM_BIST_ERRCNT_EN: when defined, every read is compared and
// counted and the run always completes; when undefined, the first mismatch
// aborts the run and in-flight reads are discarded.
// RD_LAT is legal from 1 to 4.
module ram_bist_master
    import ram_bist_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            DW       = DW_DEF,
    parameter logic [DW-1:0] PAT_SEED = PAT_SEED_DEF,
    parameter logic [DW-1:0] PAT_STEP = PAT_STEP_DEF,
    parameter int            RD_LAT   = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
`ifdef RAM_BIST_ERRCNT_EN
    output logic [AW:0]   err_count,
`endif
    ram_bist_if.master    ram
);

    localparam logic [AW-1:0] LAST_ADDR  = '1;
    localparam logic [2:0]    DRAIN_LAST = 3'(RD_LAT - 1);
`ifdef RAM_BIST_ERRCNT_EN
    localparam logic [AW:0]   ERR_MAX    = {1'b1, {AW{1'b0}}};
`endif

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return DW'(pat_data(32'(a), 32'(PAT_SEED), 32'(PAT_STEP)));
    endfunction

    state_t        state;
    logic [2:0]    drain_cnt;
    logic [AW-1:0] addr_nxt;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic          mismatch;
    logic          abort;

    // Wraps LAST_ADDR -> 0, which is exactly the restart needed at WRITE->READ.
    assign addr_nxt = ram.ram_addr + AW'(1);
    assign mismatch = out_valid && (ram.ram_rdata != pattern(out_addr));

`ifdef RAM_BIST_ERRCNT_EN
    assign abort = 1'b0;
`else
    assign abort = mismatch;
`endif

    // A read is in flight for every cycle spent in READ.
    ram_bist_rd_pipe #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (state == READ),
        .in_addr   (ram.ram_addr),
        .out_valid (out_valid),
        .out_addr  (out_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_addr     <= '0;
            ram.ram_wr    <= RAM_WR_READ;
            ram.ram_addr  <= '0;
            ram.ram_wdata <= '0;
`ifdef RAM_BIST_ERRCNT_EN
            err_count     <= '0;
`endif
        end else begin
            done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= WRITE;
                        busy          <= 1'b1;
                        pass          <= 1'b1;
                        fail_addr     <= '0;
                        ram.ram_wr    <= RAM_WR_WRITE;
                        ram.ram_addr  <= '0;
                        ram.ram_wdata <= pattern('0);
`ifdef RAM_BIST_ERRCNT_EN
                        err_count     <= '0;
`endif
                    end
                end

                WRITE: begin
                    ram.ram_addr <= addr_nxt;
                    if (ram.ram_addr == LAST_ADDR) begin
                        // Last write data stays on the bus through the reads.
                        state      <= READ;
                        ram.ram_wr <= RAM_WR_READ;
                    end else begin
                        ram.ram_wdata <= pattern(addr_nxt);
                    end
                end

                READ: begin
                    ram.ram_addr <= addr_nxt;
                    if (ram.ram_addr == LAST_ADDR) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // pass is preset at start, so it still being high marks the first miss.
            if (mismatch) begin
                if (pass) begin
                    pass      <= 1'b0;
                    fail_addr <= out_addr;
                end
`ifdef RAM_BIST_ERRCNT_EN
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + (AW+1)'(1);
                end
`else
                state        <= DONE;
                busy         <= 1'b0;
                done         <= 1'b1;
                ram.ram_addr <= '0;
`endif
            end
        end
    end

endmodule
